// File: rtl/ddc_pkg.sv
// ddc_pkg: shared widths, bus offsets and output narrowing (DDC_ACCUM_SATURATE_EN selects clamp vs wrap)
package ddc_pkg;
  localparam int IN_W = 31;
  localparam int LOG2_MAX = 16;
  localparam int OUT_W = 32;
  localparam int ACC_W = IN_W + LOG2_MAX;
  localparam int I_LSB = 0;
  localparam int Q_LSB = 32;
  function automatic logic signed [OUT_W-1:0] sat_trunc(input logic signed [ACC_W-1:0] value, input int width);
`ifdef DDC_ACCUM_SATURATE_EN
    logic signed [ACC_W-1:0] hi, lo;
    hi = (ACC_W'(1) <<< (width - 1)) - ACC_W'(1);
    lo = ~hi;
    return value > hi ? OUT_W'(hi) : value < lo ? OUT_W'(lo) : OUT_W'(value);
`else
    return OUT_W'((value <<< (ACC_W - width)) >>> (ACC_W - width));
`endif
  endfunction
endpackage

// File: rtl/ddc_accum_if.sv
// ddc_accum_if: sample input + AXI4-Stream output; slave = accumulator side, master = source/sink side
interface ddc_accum_if;
  logic [63:0] data_in;
  logic valid_in;
  logic [63:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  modport master(output data_in, valid_in, m_axis_tready, input m_axis_tdata, m_axis_tvalid);
  modport slave(input data_in, valid_in, m_axis_tready, output m_axis_tdata, m_axis_tvalid);
endinterface

// File: rtl/ddc_accum_lane.sv
// ddc_accum_lane: one-component integrate-and-dump; ports clk/rst, clr (restart), en (sample), last (dump), din, shift, result (comb frame result)
module ddc_accum_lane
  import ddc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic last,
  input  logic signed [IN_W-1:0] din,
  input  logic [4:0] shift,
  output logic signed [OUT_W-1:0] result
);
  logic signed [ACC_W-1:0] acc, sum;
  always_comb begin
    sum = acc + $signed({{(ACC_W-IN_W){din[IN_W-1]}}, din});
    result = sat_trunc(sum >>> shift, OUT_W);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= last ? '0 : sum;
endmodule

// File: rtl/ddc_accum.sv
// ddc_accum: decimating {Q,I} accumulator; ports clk, rst, s (stream bus), dec_log2/cfg_valid (config), overrun (sticky drop), frame_cnt (loads)
module ddc_accum
  import ddc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ddc_accum_if.slave s,
  input  logic [4:0] dec_log2,
  input  logic cfg_valid,
  output logic overrun,
  output logic [31:0] frame_cnt
);
  localparam int CW = LOG2_MAX + 1;
  localparam logic [4:0] MAX5 = 5'(LOG2_MAX);
  logic [4:0] shadow;
  logic [LOG2_MAX-1:0] cnt;
  logic en, last, frame, load, unused;
  logic signed [OUT_W-1:0] i_res, q_res;
  assign unused = ^{s.data_in[63:Q_LSB+IN_W], s.data_in[Q_LSB-1:I_LSB+IN_W]};
  assign en = s.valid_in & ~cfg_valid;
  assign last = {1'b0, cnt} == (CW'(1) << shadow) - CW'(1);
  assign frame = en & last;
  // A full register that is not being drained this cycle cannot take the new result.
  assign load = frame & (~s.m_axis_tvalid | s.m_axis_tready);
  ddc_accum_lane u_i (.clk, .rst, .clr(cfg_valid), .en, .last, .din(s.data_in[I_LSB +: IN_W]), .shift(shadow), .result(i_res));
  ddc_accum_lane u_q (.clk, .rst, .clr(cfg_valid), .en, .last, .din(s.data_in[Q_LSB +: IN_W]), .shift(shadow), .result(q_res));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      cnt <= '0;
    end else if (cfg_valid) begin
      shadow <= dec_log2 > MAX5 ? MAX5 : dec_log2;
      cnt <= '0;
    end else if (en) cnt <= last ? '0 : cnt + LOG2_MAX'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s.m_axis_tdata <= '0;
      s.m_axis_tvalid <= 1'b0;
      frame_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        s.m_axis_tdata <= {32'(q_res), 32'(i_res)};
        s.m_axis_tvalid <= 1'b1;
        frame_cnt <= frame_cnt + 32'd1;
      end else if (s.m_axis_tready) s.m_axis_tvalid <= 1'b0;
      if (cfg_valid) overrun <= 1'b0;
      else if (frame & ~load) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_ddc_accum.sv
// tb_ddc_accum: vector table + scoreboard bench for ddc_accum
module tb_ddc_accum;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, overrun;
  logic [4:0] dec_log2 = '0;
  logic [31:0] frame_cnt, exp_fc;
  logic [63:0] word;
  logic [63:0] sb[$];
  int errors = 0, checks = 0;
  ddc_accum_if bus();
  ddc_accum dut (.clk(clk), .rst(rst), .s(bus), .dec_log2(dec_log2), .cfg_valid(cfg_valid), .overrun(overrun), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  typedef struct {int i; int q; logic [63:0] exp;} vec_t;
  vec_t v[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input int i, input int q);
    bus.data_in = {32'(q), 32'(i)};
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
  endtask
  task automatic cfg(input logic [4:0] d);
    dec_log2 = d;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask
  task automatic expect_word(input logic [63:0] w);
    sb.push_back(w);
    exp_fc++;
  endtask
  task automatic drain();
    for (int c = 0; c < 20 && sb.size() > 0; c++) @(negedge clk);
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask
  always @(negedge clk)
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (sb.size() == 0) chk("unexpected_word", bus.m_axis_tdata, 64'hx);
      else begin
        word = sb.pop_front();
        chk("stream_word", bus.m_axis_tdata, word);
      end
    end
  initial begin
    v[0] = '{5, -7, 64'hFFFFFFF9_00000005};
    v[1] = '{1073741823, -1073741824, 64'hC0000000_3FFFFFFF};
    v[2] = '{-1, 1, 64'h00000001_FFFFFFFF};
    v[3] = '{0, 0, 64'h0};
    v[4] = '{-1073741824, 1073741823, 64'h3FFFFFFF_C0000000};
    exp_fc = 0;
    bus.data_in = '0;
    bus.valid_in = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_tdata", bus.m_axis_tdata, 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(negedge clk) rst = 1'b0;
    // 4-sample frame
    cfg(5'd2);
    send(10, -4);
    send(20, -4);
    send(30, -4);
    chk("frame4_not_early", 64'(bus.m_axis_tvalid), 64'd0);
    expect_word(64'hFFFFFFFC_00000019);
    send(40, -4);
    chk("frame4_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("frame4_tdata", bus.m_axis_tdata, 64'hFFFFFFFC_00000019);
    chk("frame4_cnt", 64'(frame_cnt), 64'(exp_fc));
    drain();
    // pass-through table, back to back
    cfg(5'd0);
    for (int k = 0; k < 5; k++) begin
      expect_word(v[k].exp);
      send(v[k].i, v[k].q);
      chk("pass_latency", bus.m_axis_tdata, v[k].exp);
    end
    drain();
    chk("pass_cnt", 64'(frame_cnt), 64'(exp_fc));
    // overrun: second frame dropped while held
    cfg(5'd1);
    bus.m_axis_tready = 1'b0;
    send(3, 1);
    expect_word(64'h00000002_00000004);
    send(5, 3);
    send(100, 100);
    send(100, 100);
    @(negedge clk);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_held", bus.m_axis_tdata, 64'h00000002_00000004);
    chk("ovr_cnt", 64'(frame_cnt), 64'(exp_fc));
    cfg(5'd1);
    chk("ovr_cleared", 64'(overrun), 64'd0);
    chk("ovr_still_valid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("ovr_still_data", bus.m_axis_tdata, 64'h00000002_00000004);
    bus.m_axis_tready = 1'b1;
    drain();
    // config and sample collide mid-frame
    cfg(5'd2);
    send(100, 7);
    bus.data_in = {32'd500, 32'd1000};
    bus.valid_in = 1'b1;
    cfg(5'd2);
    bus.valid_in = 1'b0;
    send(4, -1);
    send(8, -1);
    send(12, -1);
    chk("collide_not_early", 64'(bus.m_axis_tvalid), 64'd0);
    expect_word(64'hFFFFFFFF_0000000A);
    send(16, -1);
    drain();
    // clamp to 2^16 samples, full-scale
    cfg(5'd31);
    for (int k = 0; k < 65535; k++) send(1073741823, -1073741824);
    chk("max_not_early", 64'(bus.m_axis_tvalid), 64'd0);
    expect_word(64'hC0000000_3FFFFFFF);
    send(1073741823, -1073741824);
    chk("max_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    drain();
    chk("max_cnt", 64'(frame_cnt), 64'(exp_fc));
    // reset mid-frame
    cfg(5'd2);
    send(20, 20);
    send(20, 20);
    #2 rst = 1'b1;
    #2;
    chk("midrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("midrst_tdata", bus.m_axis_tdata, 64'd0);
    chk("midrst_cnt", 64'(frame_cnt), 64'd0);
    @(negedge clk) rst = 1'b0;
    exp_fc = 0;
    for (int k = 0; k < 4; k++) begin
      expect_word(64'hFFFFFFF8_00000008);
      send(8, -8);
      chk("midrst_word", bus.m_axis_tdata, 64'hFFFFFFF8_00000008);
    end
    drain();
    chk("midrst_frames", 64'(frame_cnt), 64'(exp_fc));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
